// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and window sizing helpers
// for the convolution row window buffer.
package conv_pkg;

  typedef enum logic [1:0] {
    FILL,
    BUILD,
    TILE
  } rowbuf_state_t;

  function automatic int pad_of(int k);
    return k / 2;
  endfunction

  function automatic int win_w_of(int k, int p);
    return p + 2 * (k / 2);
  endfunction

  function automatic int cw(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KX_DEF  = 3;
  localparam int PIX_DEF = 3;
  localparam int PAD     = pad_of(KX_DEF);
  localparam int WIN_W   = win_w_of(KX_DEF, PIX_DEF);

endpackage

// File: rtl/conv_row_window_buffer_if.sv
// conv_row_window_buffer_if: pixel stream in, padded window
// tile out, tile completion back from the kernel loop.
interface conv_row_window_buffer_if
  import conv_pkg::*;
#(
  parameter int kx    = 3,
  parameter int Pix   = 3,
  parameter int RES   = 8,
  parameter int IMG_W = 12,
  parameter int IMG_H = 12
);
  localparam int WW  = win_w_of(kx, Pix);
  localparam int RW  = cw(IMG_H);
  localparam int CLW = cw(IMG_W / Pix);

  logic [RES-1:0] pix_in;
  logic           pix_in_valid;
  logic           pix_in_ready;
  logic [RES-1:0] pixel_row [kx][WW];
  logic           pixel_ready;
  logic           tile_done;
  logic [RW-1:0]  tile_row;
  logic [CLW-1:0] tile_col;
  logic           frame_done;

  modport master (
    output pix_in, pix_in_valid, tile_done,
    input  pix_in_ready, pixel_row, pixel_ready,
    input  tile_row, tile_col, frame_done
  );

  modport slave (
    input  pix_in, pix_in_valid, tile_done,
    output pix_in_ready, pixel_row, pixel_ready,
    output tile_row, tile_col, frame_done
  );

endinterface

// File: rtl/conv_line_mem.sv
// conv_line_mem: one image row of storage, one write port and
// WW read taps returning edge-clamped data plus out-of-range flags.
module conv_line_mem
  import conv_pkg::*;
#(
  parameter int RES   = 8,
  parameter int IMG_W = 12,
  parameter int WW    = 5
)(
  input  logic                    clk,
  input  logic                    we,
  input  logic [cw(IMG_W)-1:0]    waddr,
  input  logic [RES-1:0]          wdata,
  input  int                      base_col,
  output logic [WW-1:0][RES-1:0]  tap_data,
  output logic [WW-1:0]           tap_oor
);
  localparam int AW = cw(IMG_W);

  logic [RES-1:0] mem [IMG_W];

  // raster write of the incoming row
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // taps read the clamped column so the parent can replicate edges
  always_comb begin
    int col;
    col = 0;
    for (int j = 0; j < WW; j++) begin
      col = base_col + j;
      tap_oor[j] = (col < 0) || (col >= IMG_W);
      if (col < 0) col = 0;
      else if (col >= IMG_W) col = IMG_W - 1;
      tap_data[j] = mem[AW'(col)];
    end
  end

endmodule

// File: rtl/conv_row_window_buffer.sv
// conv_row_window_buffer: circular kx-row line store feeding padded
// window tiles. CONV_ROWBUF_REPLICATE_EN: replicate edges, else zero pad.
module conv_row_window_buffer
  import conv_pkg::*;
#(
  parameter int kx    = 3,
  parameter int Pix   = 3,
  parameter int RES   = 8,
  parameter int IMG_W = 12,
  parameter int IMG_H = 12
)(
  input logic clk,
  input logic rst_n,
  conv_row_window_buffer_if.slave bus
);
  localparam int PD  = pad_of(kx);
  localparam int WW  = win_w_of(kx, Pix);
  localparam int NT  = IMG_W / Pix;
  localparam int RW  = cw(IMG_H);
  localparam int CLW = cw(NT);
  localparam int LW  = cw(IMG_H + 1);
  localparam int AW  = cw(IMG_W);
  localparam int SW  = cw(kx);

  rowbuf_state_t state;
  logic [RW-1:0]  row_q;
  logic [CLW-1:0] col_q;
  logic [LW-1:0]  rows_q;
  logic [AW-1:0]  wr_col;
  logic           frame_done_q;

  logic [RES-1:0] win_q [kx][WW];
  logic [RES-1:0] win_d [kx][WW];
  logic [WW-1:0][RES-1:0] tap_d [kx];
  logic [WW-1:0]  tap_oor [kx];

  logic [SW-1:0] wr_slot;
  logic          accept;
  logic          last_col;
  logic          last_row;
  int            base_col;
  int            need;

  assign accept   = (state == FILL) && bus.pix_in_valid;
  assign wr_slot  = SW'(int'(rows_q) % kx);
  assign last_col = col_q == CLW'(NT - 1);
  assign last_row = row_q == RW'(IMG_H - 1);

  // rows that must be resident before tile row r can be built
  always_comb begin
    need = int'(row_q) + PD + 1;
    if (need > IMG_H) need = IMG_H;
    base_col = int'(col_q) * Pix - PD;
  end

  for (genvar s = 0; s < kx; s++) begin : g_line
    conv_line_mem #(
      .RES   (RES),
      .IMG_W (IMG_W),
      .WW    (WW)
    ) u_mem (
      .clk      (clk),
      .we       (accept && (wr_slot == SW'(s))),
      .waddr    (wr_col),
      .wdata    (bus.pix_in),
      .base_col (base_col),
      .tap_data (tap_d[s]),
      .tap_oor  (tap_oor[s])
    );
  end

  // map window row i to its storage slot and pad outside the image
  always_comb begin
    int rr;
    int cr;
    logic [SW-1:0] sl;
    rr = 0;
    cr = 0;
    sl = '0;
    for (int i = 0; i < kx; i++) begin
      rr = int'(row_q) - PD + i;
      cr = (rr < 0) ? 0 : ((rr >= IMG_H) ? IMG_H - 1 : rr);
      sl = SW'(cr % kx);
      for (int j = 0; j < WW; j++) begin
`ifdef CONV_ROWBUF_REPLICATE_EN
        win_d[i][j] = tap_d[sl][j];
`else
        win_d[i][j] = ((rr < 0) || (rr >= IMG_H) || tap_oor[sl][j]) ?
                      '0 : tap_d[sl][j];
`endif
      end
    end
  end

  // FILL / BUILD / TILE sequencing with registered window and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FILL;
      row_q        <= '0;
      col_q        <= '0;
      rows_q       <= '0;
      wr_col       <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < kx; i++)
        for (int j = 0; j < WW; j++)
          win_q[i][j] <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state)
        FILL: begin
          if (bus.pix_in_valid) begin
            if (wr_col == AW'(IMG_W - 1)) begin
              wr_col <= '0;
              rows_q <= rows_q + 1'b1;
              if (int'(rows_q) + 1 >= need) state <= BUILD;
            end else begin
              wr_col <= wr_col + 1'b1;
            end
          end
        end
        BUILD: begin
          win_q <= win_d;
          state <= TILE;
        end
        TILE: begin
          if (bus.tile_done) begin
            if (!last_col) begin
              col_q <= col_q + 1'b1;
              state <= BUILD;
            end else if (!last_row) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
              state <= (int'(row_q) + 1 + PD < IMG_H) ? FILL : BUILD;
            end else begin
              frame_done_q <= 1'b1;
              row_q        <= '0;
              col_q        <= '0;
              rows_q       <= '0;
              wr_col       <= '0;
              state        <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.pix_in_ready = state == FILL;
  assign bus.pixel_ready  = state == TILE;
  assign bus.pixel_row    = win_q;
  assign bus.tile_row     = row_q;
  assign bus.tile_col     = col_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv_row_window_buffer.sv
// tb_conv_row_window_buffer: directed frame with literal windows, then
// randomized frames checked against an image-array window model.
module tb_conv_row_window_buffer;

  localparam int KX  = 3;
  localparam int PIX = 3;
  localparam int RES = 8;
  localparam int W   = 6;
  localparam int H   = 4;
  localparam int PD  = KX / 2;
  localparam int WW  = PIX + 2 * PD;
  localparam int NT  = W / PIX;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  conv_row_window_buffer_if #(
    .kx(KX), .Pix(PIX), .RES(RES), .IMG_W(W), .IMG_H(H)
  ) bus ();

  conv_row_window_buffer #(
    .kx(KX), .Pix(PIX), .RES(RES), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] img [H][W];
  int exp_r = 0;
  int exp_c = 0;
  int ptr   = 0;

  // window element expected from image coordinates alone
  function automatic logic [7:0] exp_px(int r, int c, int i, int j);
    int rr = r - PD + i;
    int cc = c * PIX - PD + j;
`ifdef CONV_ROWBUF_REPLICATE_EN
    if (rr < 0) rr = 0;
    if (rr > H - 1) rr = H - 1;
    if (cc < 0) cc = 0;
    if (cc > W - 1) cc = W - 1;
`else
    if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 8'd0;
`endif
    return img[rr][cc];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_row(input string nm, input int i, input int e0,
                         input int e1, input int e2, input int e3,
                         input int e4);
    int e [WW];
    int bad;
    e = '{e0, e1, e2, e3, e4};
    bad = -1;
    for (int j = 0; j < WW; j++)
      if (bus.pixel_row[i][j] !== 8'(e[j]) && bad < 0) bad = j;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: row[%0d][%0d] got %0d, expected %0d",
               nm, i, bad, bus.pixel_row[i][bad], e[bad]);
    end
  endtask

  task automatic chk_zero_win(input string nm);
    int nz;
    nz = 0;
    for (int i = 0; i < KX; i++)
      for (int j = 0; j < WW; j++)
        if (bus.pixel_row[i][j] !== 8'd0) nz++;
    chk(nm, nz, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!bus.pixel_ready && n < 100) begin
      tick();
      n++;
    end
    chk({nm, "_wait"}, bus.pixel_ready, 1);
  endtask

  task automatic pulse();
    logic adv;
    adv = bus.pixel_ready;
    bus.tile_done = 1'b1;
    tick();
    bus.tile_done = 1'b0;
    if (adv) begin
      if (exp_c == NT - 1) begin
        exp_c = 0;
        exp_r = (exp_r == H - 1) ? 0 : exp_r + 1;
      end else begin
        exp_c++;
      end
    end
  endtask

  // mode 0: valid always, 1: toggling, 2: random
  task automatic feed(input int n, input int mode, input int done_at);
    int got;
    int cyc;
    logic v;
    logic acc;
    got = 0;
    cyc = 0;
    v = 1'b1;
    while (got < n && cyc < 2000) begin
      bus.pix_in = img[ptr / W][ptr % W];
      case (mode)
        0: bus.pix_in_valid = 1'b1;
        1: bus.pix_in_valid = v;
        default: bus.pix_in_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (done_at >= 0) bus.tile_done = (cyc == done_at);
      acc = bus.pix_in_valid && bus.pix_in_ready;
      tick();
      if (acc) begin
        got++;
        ptr++;
      end
      v = ~v;
      cyc++;
    end
    bus.pix_in_valid = 1'b0;
    if (done_at >= 0) bus.tile_done = 1'b0;
    chk("feed_count", got, n);
  endtask

  task automatic consume_frame();
    for (int t = 0; t < H * NT; t++) begin
      wait_ready("tile");
      repeat ($urandom_range(0, 3)) tick();
      pulse();
      chk("drop_after_done", bus.pixel_ready, 0);
    end
    chk("frame_done_pulse", bus.frame_done, 1);
    chk("ready_after_frame", bus.pix_in_ready, 1);
    tick();
    chk("frame_done_clear", bus.frame_done, 0);
  endtask

  // every TILE cycle: window, tile position, and input held off
  always @(negedge clk) begin
    int bi;
    int bj;
    logic bad;
    if (rst_n && bus.pixel_ready) begin
      bad = 1'b0;
      bi = 0;
      bj = 0;
      for (int i = 0; i < KX; i++)
        for (int j = 0; j < WW; j++)
          if (bus.pixel_row[i][j] !== exp_px(exp_r, exp_c, i, j)) begin
            if (!bad) begin
              bi = i;
              bj = j;
            end
            bad = 1'b1;
          end
      n_chk++;
      if (bad) begin
        n_fail++;
        $display("FAIL window tile(%0d,%0d) [%0d][%0d]: got %0d, expected %0d",
                 exp_r, exp_c, bi, bj, bus.pixel_row[bi][bj],
                 exp_px(exp_r, exp_c, bi, bj));
      end
      chk("mon_tile_row", bus.tile_row, exp_r);
      chk("mon_tile_col", bus.tile_col, exp_c);
      chk("mon_no_input", bus.pix_in_ready, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.pix_in       = '0;
    bus.pix_in_valid = 1'b0;
    bus.tile_done    = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'(16 * r + c);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_pixel_ready", bus.pixel_ready, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_pix_in_ready", bus.pix_in_ready, 1);
    chk_zero_win("rst_window");

    feed(5, 0, -1);
    rst_n = 1'b0;
    #2;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_pixel_ready", bus.pixel_ready, 0);
    chk("mid_rst_frame_done", bus.frame_done, 0);
    chk("mid_rst_pix_in_ready", bus.pix_in_ready, 1);
    chk("mid_rst_tile_row", bus.tile_row, 0);
    chk_zero_win("mid_rst_window");
    ptr = 0;
    exp_r = 0;
    exp_c = 0;

    feed(12, 0, -1);
    chk("fill_ready_drop", bus.pix_in_ready, 0);
    chk("build_not_ready", bus.pixel_ready, 0);
    tick();
    chk("first_tile_ready", bus.pixel_ready, 1);
    chk("first_tile_row", bus.tile_row, 0);
    chk("first_tile_col", bus.tile_col, 0);
`ifdef CONV_ROWBUF_REPLICATE_EN
    chk_row("t00_r0", 0, 0, 0, 1, 2, 3);
    chk_row("t00_r1", 1, 0, 0, 1, 2, 3);
    chk_row("t00_r2", 2, 16, 16, 17, 18, 19);
`else
    chk_row("t00_r0", 0, 0, 0, 0, 0, 0);
    chk_row("t00_r1", 1, 0, 0, 1, 2, 3);
    chk_row("t00_r2", 2, 0, 16, 17, 18, 19);
`endif

    pulse();
    chk("done_drop", bus.pixel_ready, 0);
    tick();
    chk("next_tile_ready", bus.pixel_ready, 1);
    chk("next_tile_col", bus.tile_col, 1);
`ifdef CONV_ROWBUF_REPLICATE_EN
    chk_row("t01_r1", 1, 2, 3, 4, 5, 5);
`else
    chk_row("t01_r1", 1, 2, 3, 4, 5, 0);
`endif

    pulse();
    chk("refill_ready", bus.pix_in_ready, 1);
    feed(6, 1, 2);
    chk("refill_build", bus.pixel_ready, 0);
    tick();
    chk("t10_ready", bus.pixel_ready, 1);
    chk("t10_row", bus.tile_row, 1);
    chk("t10_col", bus.tile_col, 0);
`ifdef CONV_ROWBUF_REPLICATE_EN
    chk_row("t10_r2", 2, 32, 32, 33, 34, 35);
`else
    chk_row("t10_r2", 2, 0, 32, 33, 34, 35);
`endif

    pulse();
    wait_ready("t11");
    pulse();
    feed(6, 0, -1);
    wait_ready("t20");
    pulse();
    wait_ready("t21");
    pulse();
    chk("bottom_no_fill", bus.pix_in_ready, 0);
    tick();
    chk("t30_ready", bus.pixel_ready, 1);
    chk("t30_row", bus.tile_row, 3);
`ifdef CONV_ROWBUF_REPLICATE_EN
    chk_row("t30_r2", 2, 48, 48, 49, 50, 51);
`else
    chk_row("t30_r2", 2, 0, 0, 0, 0, 0);
`endif
    pulse();
    wait_ready("t31");
    pulse();
    chk("frame_done_high", bus.frame_done, 1);
    chk("frame_pix_in_ready", bus.pix_in_ready, 1);
    chk("frame_tile_row", bus.tile_row, 0);
    chk("frame_tile_col", bus.tile_col, 0);
    tick();
    chk("frame_done_one_cycle", bus.frame_done, 0);

    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[r][c] = 8'($urandom);
      ptr = 0;
      fork
        feed(H * W, 2, -1);
        consume_frame();
      join
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
